// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns an LFSR-chosen mole pattern each round,
// holds it for a window that shrinks every round, clears the board, pauses,
// and repeats for ROUNDS rounds while accumulating a saturating hit score.
module mole_round_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned STEP_CYCLES   = 2500000,
  parameter int unsigned MIN_WINDOW    = 10000000,
  parameter int unsigned GAP_CYCLES    = 12500000,
  parameter int unsigned ROUNDS        = 16,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       score_trigger_i,
  input  logic [4:0] board_state_i,
  output logic       load_o,
  output logic [4:0] loadval_o,
  output logic [7:0] score_o,
  output logic [4:0] round_o,
  output logic       busy_o,
  output logic       game_over_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPAWN  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] WIN_INIT = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] WIN_STEP = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(MIN_WINDOW);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_RND = 5'(ROUNDS);
  // Threshold kept at 32 bits so MIN+STEP cannot wrap inside the timer width.
  localparam int unsigned      WIN_FLOOR_AT = MIN_WINDOW + STEP_CYCLES;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [15:0]      lfsr_q;
  logic             first_q, first_d;
  logic             load_q, load_d;
  logic [4:0]       loadval_q, loadval_d;
  logic [7:0]       score_q, score_d;
  logic [4:0]       round_q, round_d;
  logic             busy_q, busy_d;
  logic             game_over_q, game_over_d;
  logic [4:0]       pattern;

  // All-zero pattern would spawn no moles, so substitute a single mole.
  assign pattern = (lfsr_q[4:0] == 5'd0) ? 5'b00001 : lfsr_q[4:0];

  // Free-running Fibonacci LFSR, taps 16,14,13,11; runs in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Next-state and registered-output computation for the round sequencer.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    window_d    = window_q;
    first_d     = 1'b0;
    load_d      = 1'b0;
    loadval_d   = loadval_q;
    score_d     = score_q;
    round_d     = round_q;
    busy_d      = busy_q;
    game_over_d = game_over_q;

    // Hits only count while a game runs, including the CLEAR cycle.
    if (busy_q && score_trigger_i && (score_q != 8'hFF)) score_d = score_q + 8'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_SPAWN;
          round_d     = 5'd1;
          score_d     = 8'd0;
          window_d    = WIN_INIT;
          load_d      = 1'b1;
          loadval_d   = pattern;
          busy_d      = 1'b1;
          game_over_d = 1'b0;
        end
      end
      S_SPAWN: begin
        state_d = S_ACTIVE;
        timer_d = window_q - CNT_ONE;
        first_d = 1'b1;
      end
      S_ACTIVE: begin
        timer_d = timer_q - CNT_ONE;
        // First ACTIVE cycle still sees the pre-load board, so skip the empty check.
        if ((timer_q == '0) || (!first_q && (board_state_i == 5'd0))) begin
          state_d   = S_CLEAR;
          load_d    = 1'b1;
          loadval_d = 5'd0;
        end
      end
      S_CLEAR: begin
        window_d = (32'(window_q) <= WIN_FLOOR_AT) ? WIN_MIN : (window_q - WIN_STEP);
        if (round_q == LAST_RND) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          game_over_d = 1'b1;
        end else begin
          state_d = S_GAP;
          timer_d = GAP_LAST;
        end
      end
      S_GAP: begin
        timer_d = timer_q - CNT_ONE;
        if (timer_q == '0) begin
          state_d   = S_SPAWN;
          round_d   = round_q + 5'd1;
          load_d    = 1'b1;
          loadval_d = pattern;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      window_q    <= WIN_INIT;
      first_q     <= 1'b0;
      load_q      <= 1'b0;
      loadval_q   <= 5'd0;
      score_q     <= 8'd0;
      round_q     <= 5'd0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      window_q    <= window_d;
      first_q     <= first_d;
      load_q      <= load_d;
      loadval_q   <= loadval_d;
      score_q     <= score_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign load_o      = load_q;
  assign loadval_o   = loadval_q;
  assign score_o     = score_q;
  assign round_o     = round_q;
  assign busy_o      = busy_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized bench for mole_round_ctrl. Two instances share start/trigger:
// d0 uses the small 20-cycle window, d1 a 400-cycle window so the score can
// saturate. Each has its own board model and a phase/elapsed-count reference.
module tb_mole_round_ctrl;

  localparam int STEP = 4, MINW = 8, GAP = 3, RNDS = 4;
  localparam int PH_IDLE = 0, PH_SPAWN = 1, PH_ACTIVE = 2, PH_CLEAR = 3, PH_GAP = 4, PH_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic trig = 1'b0;
  logic [1:0] whack = 2'b00;
  logic [1:0][4:0] mask;
  logic [1:0] load, busy, gover;
  logic [1:0][4:0] loadval, rnd;
  logic [1:0][7:0] score;

  int n_vec = 0;
  int n_err = 0;
  int p_start, p_trig, p_whack;

  int m_ph[2], m_cnt[2], m_win[2], m_rnd[2], m_sc[2], m_pat[2];
  logic [15:0] m_lfsr[2];
  int P_W[2] = '{20, 400};

  always #5 clk = ~clk;

  mole_round_ctrl #(.WINDOW_CYCLES(20), .STEP_CYCLES(STEP), .MIN_WINDOW(MINW),
                    .GAP_CYCLES(GAP), .ROUNDS(RNDS), .CNT_W(8)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .score_trigger_i(trig),
    .board_state_i(mask[0]), .load_o(load[0]), .loadval_o(loadval[0]),
    .score_o(score[0]), .round_o(rnd[0]), .busy_o(busy[0]), .game_over_o(gover[0]));

  mole_round_ctrl #(.WINDOW_CYCLES(400), .STEP_CYCLES(STEP), .MIN_WINDOW(MINW),
                    .GAP_CYCLES(GAP), .ROUNDS(RNDS), .CNT_W(10)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .score_trigger_i(trig),
    .board_state_i(mask[1]), .load_o(load[1]), .loadval_o(loadval[1]),
    .score_o(score[1]), .round_o(rnd[1]), .busy_o(busy[1]), .game_over_o(gover[1]));

  // Board models: latch a load, otherwise a player whack empties the board.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask <= '0;
    else begin
      if (load[0]) mask[0] <= loadval[0]; else if (whack[0]) mask[0] <= 5'd0;
      if (load[1]) mask[1] <= loadval[1]; else if (whack[1]) mask[1] <= 5'd0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = PH_IDLE; m_cnt[k] = 0; m_win[k] = P_W[k];
      m_rnd[k] = 0; m_sc[k] = 0; m_pat[k] = 0; m_lfsr[k] = 16'hACE1;
    end
  endtask

  // One clock of game rules for instance k, given this cycle's inputs.
  task automatic model_step(input int k, input bit st, input bit tr, input logic [4:0] bs);
    logic [15:0] l;
    int p;
    bit running;
    l = m_lfsr[k];
    p = (l[4:0] == 5'd0) ? 1 : int'(l[4:0]);
    running = (m_ph[k] >= PH_SPAWN) && (m_ph[k] <= PH_GAP);
    if (running && tr && m_sc[k] < 255) m_sc[k]++;
    case (m_ph[k])
      PH_IDLE, PH_DONE: if (st) begin
        m_rnd[k] = 1; m_sc[k] = 0; m_win[k] = P_W[k]; m_pat[k] = p; m_ph[k] = PH_SPAWN;
      end
      PH_SPAWN: begin m_ph[k] = PH_ACTIVE; m_cnt[k] = 0; end
      PH_ACTIVE: begin
        m_cnt[k]++;
        if (m_cnt[k] == m_win[k] || (m_cnt[k] >= 2 && bs == 5'd0)) m_ph[k] = PH_CLEAR;
      end
      PH_CLEAR: begin
        m_win[k] = (m_win[k] <= MINW + STEP) ? MINW : m_win[k] - STEP;
        if (m_rnd[k] == RNDS) m_ph[k] = PH_DONE;
        else begin m_ph[k] = PH_GAP; m_cnt[k] = 0; end
      end
      PH_GAP: begin
        m_cnt[k]++;
        if (m_cnt[k] == GAP) begin m_rnd[k]++; m_pat[k] = p; m_ph[k] = PH_SPAWN; end
      end
      default: m_ph[k] = PH_IDLE;
    endcase
    m_lfsr[k] = {l[14:0], ^(l & 16'hB400)};
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      bit el;
      el = (m_ph[k] == PH_SPAWN) || (m_ph[k] == PH_CLEAR);
      chk($sformatf("d%0d.load", k), int'(load[k]), int'(el));
      if (el) chk($sformatf("d%0d.loadval", k), int'(loadval[k]), (m_ph[k] == PH_SPAWN) ? m_pat[k] : 0);
      chk($sformatf("d%0d.score", k), int'(score[k]), m_sc[k]);
      chk($sformatf("d%0d.round", k), int'(rnd[k]), m_rnd[k]);
      chk($sformatf("d%0d.busy", k), int'(busy[k]), int'(m_ph[k] >= PH_SPAWN && m_ph[k] <= PH_GAP));
      chk($sformatf("d%0d.game_over", k), int'(gover[k]), int'(m_ph[k] == PH_DONE));
    end
  endtask

  // Check outputs, then drive this cycle's random inputs and advance the model.
  task automatic body();
    compare_all();
    start = ($urandom_range(99) < p_start);
    trig  = ($urandom_range(99) < p_trig);
    whack[0] = ($urandom_range(99) < p_whack);
    whack[1] = ($urandom_range(99) < p_whack);
    model_step(0, start, trig, mask[0]);
    model_step(1, start, trig, mask[1]);
  endtask

  task automatic cycle();
    @(negedge clk);
    body();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; trig = 1'b0; whack = 2'b00;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    body();
  endtask

  initial begin
    int waited;
    model_reset();
    p_start = 5; p_trig = 15; p_whack = 10;
    do_reset();

    // Mixed play: early whacks, sparse hits, starts landing in every state.
    repeat (1500) cycle();

    // Drive d0 to round 2 ACTIVE, then pull reset mid-game.
    p_start = 50;
    waited = 0;
    while (!(m_ph[0] == PH_ACTIVE && m_rnd[0] == 2) && waited < 2000) begin
      cycle();
      waited++;
    end
    chk("reach_r2_active", int'(m_ph[0] == PH_ACTIVE && m_rnd[0] == 2), 1);
    do_reset();

    // Dense hits, no whacks: d1 must saturate at 255.
    p_start = 3; p_trig = 75; p_whack = 0;
    repeat (2500) cycle();

    // Mixed play again with frequent whacks.
    p_start = 8; p_trig = 30; p_whack = 25;
    repeat (800) cycle();
    @(negedge clk);
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game sequencer for the whack-a-mole board-state block.
- Chooses a pseudo-random mole pattern each round and loads it into the board through load/loadval.
- Keeps the pattern up for a time window that shrinks every round, then clears the board, pauses, and starts the next round.
- Counts score_trigger pulses into a saturating score and stops after a fixed number of rounds.

Parameters:
- WINDOW_CYCLES, 50000000: cycles the moles stay up in round 1.
- STEP_CYCLES, 2500000: window reduction applied after each round.
- MIN_WINDOW, 10000000: floor for the window length.
- GAP_CYCLES, 12500000: pause between rounds with the board empty.
- ROUNDS, 16: rounds per game, range 1..31.
- CNT_W, 26: timer width; must hold max(WINDOW_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  active-high pulse; starts a game from IDLE or DONE.
- score_trigger  in  1  active-high pulse from the board block on a valid hit.
- board_state  in  5  live mole mask from the board block; 1 = mole up.
- load  out  1  active-high; board block takes loadval on this clock edge.
- loadval  out  5  pattern to load.
- score  out  8  hits this game, saturating.
- round  out  5  current round, 1-based; 0 in IDLE.
- busy  out  1  high while a game is running.
- game_over  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - state=IDLE; load=0, loadval=0, score=0, round=0, busy=0, game_over=0.
  - LFSR=16'hACE1; timer=0; window=WINDOW_CYCLES.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle in every state, including IDLE.
  - Pattern = lfsr[4:0]; a zero value is replaced by 5'b00001.
- State IDLE:
  - On start: round=1, score=0, window=WINDOW_CYCLES, go to SPAWN.
- State SPAWN (1 cycle):
  - load=1, loadval=pattern, busy=1.
  - Next state ACTIVE; timer=window-1.
- State ACTIVE:
  - load=0; timer decrements each cycle.
  - Go to CLEAR when timer==0.
  - Also go to CLEAR when board_state==0, checked only from the 2nd ACTIVE cycle onward. This allows for the board's one-cycle load latency.
- State CLEAR (1 cycle):
  - load=1, loadval=0.
  - Window update: window = max(window-STEP_CYCLES, MIN_WINDOW), computed without underflow. If window<=MIN_WINDOW+STEP_CYCLES, the result is MIN_WINDOW.
  - If round==ROUNDS, go to DONE; otherwise timer=GAP_CYCLES-1 and go to GAP.
- State GAP:
  - load=0; timer decrements.
  - When timer==0: round=round+1, go to SPAWN.
- State DONE:
  - game_over=1, busy=0; score and round hold their values.
  - On start: behave as IDLE start (score cleared, round=1, next state SPAWN); game_over falls on the next cycle.
- start is ignored when busy=1.
- Score:
  - Increments by 1 on each cycle with score_trigger=1 while busy=1.
  - Saturates at 255.
  - A trigger in the same cycle as the CLEAR load still counts.
  - Triggers in IDLE or DONE are ignored.
- busy=1 in SPAWN, ACTIVE, CLEAR and GAP.
- Exactly one load pulse in SPAWN and one in CLEAR per round; load is never asserted two cycles in a row.
- Reset mid-game: everything returns to reset values at once. The board block's own reset clears its mask.

Test Plan:
- Bench parameters for all cases: WINDOW_CYCLES=20, STEP_CYCLES=4, MIN_WINDOW=8, GAP_CYCLES=3, ROUNDS=4.
- Case 1: reset, then start pulse, no hits.
  - load with nonzero loadval in cycle 2.
  - CLEAR load (loadval=0) 20 cycles later.
  - Round-2 SPAWN 3 cycles after that.
  - Windows across rounds are 20/16/12/8.
  - game_over=1 after round 4; score=0.
- Case 2: board model clears its mask on the 5th ACTIVE cycle.
  - CLEAR occurs on the next cycle instead of after 20.
  - Round advances; the window still drops to 16.
- Case 3: pulse score_trigger 3 times in round 1 and twice in DONE.
  - score=3; the pulses in DONE are ignored.
- Case 4: force 300 score_trigger pulses during a game (window widened).
  - score stays at 255.
- Case 5: start pulse while busy=1.
  - No change to round, score or state.
  - start in DONE restarts with score=0, round=1.
- Case 6: assert rst_n=0 during ACTIVE of round 2.
  - load, busy, round and score go to 0 immediately.
  - First pattern after re-start matches the post-reset LFSR sequence.
